// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if
// Groups the two handshakes of the ALU result stage into one bundle.
//   Upstream side  : in_valid / in_ready with the adder result fields
//                    (y_in, carry_in, over_in, sign_in, dest_in).
//   Writeback side : out_valid / out_ready with out_data / out_dest.
// Modports:
//   master : the surroundings (adder plus writeback port), drives in_* and out_ready.
//   slave  : the result stage itself, drives in_ready and out_*.
interface alu_result_stage_if #(
    parameter int unsigned W      = 16,
    parameter int unsigned DEST_W = 3
);
    // Upstream result handshake
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      y_in;
    logic              carry_in;
    logic              over_in;
    logic              sign_in;
    logic [DEST_W-1:0] dest_in;

    // Writeback handshake
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [DEST_W-1:0] out_dest;

    modport master (
        output in_valid,
        input  in_ready,
        output y_in,
        output carry_in,
        output over_in,
        output sign_in,
        output dest_in,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_dest
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  y_in,
        input  carry_in,
        input  over_in,
        input  sign_in,
        input  dest_in,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_dest
    );
endinterface

// File: rtl/alu_result_stage.sv
// alu_result_stage
// Registered result and status stage behind the 16-bit add/subtract unit.
// Accepted results are queued in a 2-entry FIFO for the register-file writeback
// port, and every accepted result updates the processor status flags.
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   bus         alu_result_stage_if.slave: upstream and writeback handshakes
//   clr_sticky  synchronous clear of sticky_v (an overflow accept in the same cycle wins)
//   flag_c      carry of the last accepted result
//   flag_v      overflow of the last accepted result
//   flag_z      last accepted result was zero
//   flag_n      last accepted result was negative (signed operations only)
//   sticky_v    an overflow has been accepted since the last clear
module alu_result_stage #(
    parameter int unsigned W      = 16,
    parameter int unsigned DEST_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_result_stage_if.slave   bus,
    input  logic                clr_sticky,
    output logic                flag_c,
    output logic                flag_v,
    output logic                flag_z,
    output logic                flag_n,
    output logic                sticky_v
);

    localparam logic [1:0] CntEmpty = 2'd0;
    localparam logic [1:0] CntFull  = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;

    logic [W-1:0]      data_q [2];
    logic [DEST_W-1:0] dest_q [2];

    logic              flag_c_q, flag_c_d;
    logic              flag_v_q, flag_v_d;
    logic              flag_z_q, flag_z_d;
    logic              flag_n_q, flag_n_d;
    logic              sticky_q, sticky_d;

    logic              accept;
    logic              pop;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // in_ready depends on the registered count only, so a FULL buffer that is
    // popped this cycle does not accept until the following cycle.
    assign bus.in_ready  = (count_q != CntFull);
    assign bus.out_valid = (count_q != CntEmpty);

    assign accept = bus.in_valid & bus.in_ready;
    assign pop    = bus.out_valid & bus.out_ready;

    assign bus.out_data = data_q[rd_ptr_q];
    assign bus.out_dest = dest_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        unique case ({accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // 1-bit pointers wrap on their own
        if (accept) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= CntEmpty;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage carries no reset; out_valid qualifies it.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q[wr_ptr_q] <= bus.y_in;
            dest_q[wr_ptr_q] <= bus.dest_in;
        end
    end

    // ------------------------------------------------------------------
    // Status flags: follow acceptance order, untouched by pops
    // ------------------------------------------------------------------
    always_comb begin
        flag_c_d = flag_c_q;
        flag_v_d = flag_v_q;
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        sticky_d = sticky_q;

        if (accept) begin
            flag_c_d = bus.carry_in;
            flag_v_d = bus.over_in;
            flag_z_d = (bus.y_in == '0);
            // Bit W-1 is only a sign for signed operations
            flag_n_d = bus.sign_in ? bus.y_in[W-1] : 1'b0;
        end

        // An overflow accept takes priority over a simultaneous clear
        if (accept && bus.over_in) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
            flag_z_q <= 1'b1;
            flag_n_q <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            flag_c_q <= flag_c_d;
            flag_v_q <= flag_v_d;
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
            sticky_q <= sticky_d;
        end
    end

    assign flag_c   = flag_c_q;
    assign flag_v   = flag_v_q;
    assign flag_z   = flag_z_q;
    assign flag_n   = flag_n_q;
    assign sticky_v = sticky_q;

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered result and status stage directly downstream of the 16-bit add/subtract unit. Each cycle it may accept one result word with its carry/overflow outputs and a destination tag through a valid/ready handshake. It holds up to two results in a buffer for the register-file writeback port. On every accepted result it updates the processor status flags: C, V, Z, N and a sticky overflow.

## Interface
- W, 16, result data width; must match the adder width.
- DEST_W, 3, destination register tag width.

- clk  input  1  system clock, all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream presents a result this cycle
- in_ready  output  1  stage can accept a result this cycle
- y_in  input  W  adder result Y
- carry_in  input  1  adder carry output (0 in signed mode)
- over_in  input  1  adder overflow output (0 in unsigned mode)
- sign_in  input  1  operation was signed (1) or unsigned (0)
- dest_in  input  DEST_W  destination register tag
- out_valid  output  1  buffer head holds a result
- out_ready  input  1  writeback port consumes head this cycle
- out_data  output  W  head result
- out_dest  output  DEST_W  head destination tag
- flag_c, flag_v, flag_z, flag_n  output  1 each  status flags
- sticky_v  output  1  overflow seen since last clear
- clr_sticky  input  1  synchronous clear of sticky_v

## Operation
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Buffer: 2-entry FIFO with write and read pointers and a 2-bit count (0/1/2 = EMPTY/ONE/FULL).
  - Pointers are 1-bit and wrap naturally.
  - in_ready = (count != 2). It is driven from registered count only and does not combinationally depend on out_ready.
- Count transitions:
  - accept only: +1
  - pop only: −1
  - accept and pop together: unchanged, with both the write and read pointers advancing.
  - FULL with pop: in_ready is still 0 that cycle, so no accept. One free slot becomes visible the next cycle.
- out_data and out_dest are read from the entry at the read pointer. While out_valid=0 they are don't-care; the bench must not check them then.
- Flag update happens only on accept. The flags are never changed by pop.
  - flag_z ← (y_in == 0)
  - flag_n ← sign_in ? y_in[W-1] : 0
  - flag_c ← carry_in
  - flag_v ← over_in
- sticky_v:
  - Set on an accept with over_in=1.
  - Cleared by clr_sticky.
  - If set and clear occur in the same cycle, set wins and sticky_v=1.
  - A clear without an overflow accept gives sticky_v=0.
- Inputs are sampled only on accept. Data presented while in_ready=0 is ignored, and upstream must hold it.

## Timing
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - count=0 and both pointers=0
  - in_ready=1, out_valid=0
  - flag_c=flag_v=flag_n=0, flag_z=1
  - sticky_v=0
  - Buffer data is not reset.
- Reset mid-operation discards all buffered entries. No output pulse occurs on release.
- Latency:
  - A result accepted at edge k is at the head with out_valid=1 after edge k, provided the buffer was empty.
  - Flags reflect that result after edge k.
- Throughput is one result per cycle while out_ready=1 continuously. With out_ready=0, at most two results are accepted, then in_ready drops after the second accept edge.
- Ordering is strict FIFO; tags always stay paired with their data.
- Flags track acceptance order, not drain order. The flags can therefore reflect a result that has not yet been written back.

## Test plan
- Reset → in_ready=1, out_valid=0, flag_z=1, other flags and sticky_v 0. Assert rst_n low while FULL → out_valid=0 and in_ready=1 immediately, before any clock edge.
- Accept y_in=0x0000, carry_in=1, sign_in=0, dest 5 with out_ready=1 → next cycle out_valid=1, out_data=0x0000, out_dest=5, flag_z=1, flag_c=1, flag_n=0.
- Signed accept y_in=0x8000, over_in=1 → flag_n=1, flag_v=1, sticky_v=1. Then accept 0x0001 with over_in=0 → flag_v=0, sticky_v stays 1. Then clr_sticky → sticky_v=0.
- out_ready=0, offer 3 results 0x1111/0x2222/0x3333 → first two accepted, in_ready=0 after second. Then raise out_ready → drains 0x1111, 0x2222 in order, then 0x3333 is accepted once in_ready returns. Tags stay matched throughout.
- With count=ONE, assert accept and pop in the same cycle for 50 consecutive cycles → count stays ONE and outputs are in order with no loss.
- clr_sticky asserted in the same cycle as an accept with over_in=1 → sticky_v=1.
